// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the multi-precision adder sequencer.
// LIMB_W is fixed by the shared 8-bit adder datapath.
package adder_seq_pkg;

  localparam int LIMB_W    = 8;
  localparam int MAX_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/adder.sv
// Shared 8-bit adder datapath: sum and carry-out of a + b + c_in.
module adder
  import adder_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              c_in,
  output logic [LIMB_W-1:0] sum,
  output logic              c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, c_in};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-precision adder sequencer: adds WORDS-limb operands one limb per
// cycle, LSB first, through the shared 8-bit adder with a registered carry.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [WORDS*LIMB_W-1:0] req_a,
  input  logic [WORDS*LIMB_W-1:0] req_b,
  input  logic                    req_c_in,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WORDS*LIMB_W-1:0] rsp_sum,
  output logic                    rsp_c_out,
  output logic                    busy
);

  localparam int VEC_W = WORDS * LIMB_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  generate
    if (WORDS < 1 || WORDS > MAX_WORDS) begin : g_bad_words
      $error("adder_seq_ctrl: WORDS must be within 1..16");
    end
  endgenerate

  state_t           state;
  state_t           state_next;
  logic [VEC_W-1:0] a_q;
  logic [VEC_W-1:0] b_q;
  logic [VEC_W-1:0] result_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [LIMB_W-1:0] limb_a;
  logic [LIMB_W-1:0] limb_b;
  logic [LIMB_W-1:0] limb_sum;
  logic              limb_c_out;

  // Select the current limb of each operand for the shared adder.
  always_comb begin
    limb_a = '0;
    limb_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        limb_a = a_q[i*LIMB_W +: LIMB_W];
        limb_b = b_q[i*LIMB_W +: LIMB_W];
      end
    end
  end

  adder u_adder (
    .a     (limb_a),
    .b     (limb_b),
    .c_in  (carry_q),
    .sum   (limb_sum),
    .c_out (limb_c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs are decoded from state alone, never from req_valid/rsp_ready.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            carry_q <= req_c_in;
            idx     <= '0;
          end
        end
        RUN: begin
          carry_q <= limb_c_out;
          for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
              result_q[i*LIMB_W +: LIMB_W] <= limb_sum;
            end
          end
          if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result and carry registers stay frozen through DONE until the handshake.
  assign rsp_sum   = result_q;
  assign rsp_c_out = carry_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl: a WORDS=4 instance for the main scenarios
// and a WORDS=1 instance for the single-limb case.
module tb_adder_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_c_in;
  logic [31:0] req_a, req_b, rsp_sum;
  logic        rsp_valid, rsp_ready, rsp_c_out, busy;

  logic        w1_req_valid, w1_req_ready, w1_req_c_in;
  logic [7:0]  w1_req_a, w1_req_b, w1_rsp_sum;
  logic        w1_rsp_valid, w1_rsp_ready, w1_rsp_c_out, w1_busy;

  int checks = 0;
  int errors = 0;

  adder_seq_ctrl #(.WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c_in(req_c_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_c_out(rsp_c_out), .busy(busy)
  );

  adder_seq_ctrl #(.WORDS(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .req_valid(w1_req_valid), .req_ready(w1_req_ready),
    .req_a(w1_req_a), .req_b(w1_req_b), .req_c_in(w1_req_c_in),
    .rsp_valid(w1_rsp_valid), .rsp_ready(w1_rsp_ready),
    .rsp_sum(w1_rsp_sum), .rsp_c_out(w1_rsp_c_out), .busy(w1_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles until rsp_valid is seen, or -1 if the bound expires.
  task automatic wait_rsp(input bit sel, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if ((sel ? w1_rsp_valid : rsp_valid) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_c_in  = c;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (rsp_sum !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_sum got %h want 00000000", rsp_sum); end
    checks++; if (rsp_c_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_c_out got %b want 0", rsp_c_out); end
    checks++; if (w1_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_w1_req_ready got %b want 1", w1_req_ready); end
    checks++; if (w1_rsp_sum !== 8'h0) begin errors++; $display("[TB] FAIL reset_w1_rsp_sum got %h want 00", w1_rsp_sum); end
  endtask

  task automatic test_limb_carry();
    int n;
    rsp_ready = 1'b1;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_accept busy=%b req_ready=%b want 1/0", busy, req_ready); end
    wait_rsp(1'b0, n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL t1_latency got %0d want 4", n); end
    checks++; if (rsp_sum !== 32'h0000_0100) begin errors++; $display("[TB] FAIL t1_sum got %h want 00000100", rsp_sum); end
    checks++; if (rsp_c_out !== 1'b0) begin errors++; $display("[TB] FAIL t1_c_out got %b want 0", rsp_c_out); end
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL t1_release rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_full_ripple();
    int n;
    rsp_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_rsp(1'b0, n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL t2_latency got %0d want 4", n); end
    checks++; if (rsp_sum !== 32'h0000_0000) begin errors++; $display("[TB] FAIL t2_sum got %h want 00000000", rsp_sum); end
    checks++; if (rsp_c_out !== 1'b1) begin errors++; $display("[TB] FAIL t2_c_out got %b want 1", rsp_c_out); end
    step();
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_rsp(1'b0, n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL t3_latency got %0d want 4", n); end
    req_valid = 1'b1;
    req_a     = 32'h0101_0101;
    req_b     = 32'h0101_0101;
    req_c_in  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL t3_hold_valid cycle %0d got %b want 1", i, rsp_valid); end
      checks++; if (rsp_sum !== 32'h2345_6789) begin errors++; $display("[TB] FAIL t3_hold_sum cycle %0d got %h want 23456789", i, rsp_sum); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL t3_req_ready cycle %0d got %b want 0", i, req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL t3_after_handshake req_ready=%b busy=%b want 1/0", req_ready, busy); end
    step();
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t3_late_accept busy got %b want 1", busy); end
    wait_rsp(1'b0, n);
    checks++; if (n !== 4 || rsp_sum !== 32'h0202_0202) begin errors++; $display("[TB] FAIL t3_second_op n=%0d sum=%h want 4/02020202", n, rsp_sum); end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a     = 32'h0000_0005;
    req_b     = 32'h0000_0007;
    req_c_in  = 1'b0;
    step();
    req_a = 32'h8000_0000;
    req_b = 32'h8000_0000;
    wait_rsp(1'b0, n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL t4_lat1 got %0d want 4", n); end
    checks++; if (rsp_sum !== 32'h0000_000C || rsp_c_out !== 1'b0) begin errors++; $display("[TB] FAIL t4_rsp1 got %h/%b want 0000000c/0", rsp_sum, rsp_c_out); end
    step();
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL t4_gap req_ready=%b busy=%b want 1/0", req_ready, busy); end
    step();
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t4_accept2 busy got %b want 1", busy); end
    wait_rsp(1'b0, n);
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL t4_lat2 got %0d want 4", n); end
    checks++; if (rsp_sum !== 32'h0000_0000 || rsp_c_out !== 1'b1) begin errors++; $display("[TB] FAIL t4_rsp2 got %h/%b want 00000000/1", rsp_sum, rsp_c_out); end
    step();
  endtask

  task automatic test_reset_mid_run();
    rsp_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL t5_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL t5_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t5_busy got %b want 0", busy); end
    checks++; if (rsp_sum !== 32'h0 || rsp_c_out !== 1'b0) begin errors++; $display("[TB] FAIL t5_sum got %h/%b want 00000000/0", rsp_sum, rsp_c_out); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL t5_no_rsp cycle %0d got %b want 0", i, rsp_valid); end
    end
  endtask

  task automatic test_single_word();
    int n;
    w1_rsp_ready = 1'b1;
    w1_req_valid = 1'b1;
    w1_req_a     = 8'd200;
    w1_req_b     = 8'd100;
    w1_req_c_in  = 1'b0;
    step();
    w1_req_valid = 1'b0;
    wait_rsp(1'b1, n);
    checks++; if (n !== 1) begin errors++; $display("[TB] FAIL t6_latency got %0d want 1", n); end
    checks++; if (w1_rsp_sum !== 8'h2C || w1_rsp_c_out !== 1'b1) begin errors++; $display("[TB] FAIL t6_rsp got %h/%b want 2c/1", w1_rsp_sum, w1_rsp_c_out); end
    step();
    w1_req_valid = 1'b1;
    w1_req_a     = 8'h7F;
    w1_req_b     = 8'h80;
    w1_req_c_in  = 1'b1;
    step();
    w1_req_valid = 1'b0;
    wait_rsp(1'b1, n);
    checks++; if (n !== 1 || w1_rsp_sum !== 8'h00 || w1_rsp_c_out !== 1'b1) begin errors++; $display("[TB] FAIL t6_wrap n=%0d got %h/%b want 1 00/1", n, w1_rsp_sum, w1_rsp_c_out); end
    step();
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_a        = '0;
    req_b        = '0;
    req_c_in     = 1'b0;
    rsp_ready    = 1'b0;
    w1_req_valid = 1'b0;
    w1_req_a     = '0;
    w1_req_b     = '0;
    w1_req_c_in  = 1'b0;
    w1_rsp_ready = 1'b0;
    #2;
    test_reset();
    test_limb_carry();
    test_full_ripple();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_single_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencer that performs multi-precision addition (WORDS x 8 bits) by time-multiplexing the team's existing 8-bit adder, one limb per cycle, LSB limb first. The carry is chained through a register. Requests and responses use valid/ready handshakes. It sits between a requester (for example a checksum or accumulator unit) and the shared 8-bit adder datapath.

Parameters:
WORDS, 4, number of 8-bit limbs per operand; legal range 1..16; an elaboration-time assertion rejects values outside this range.
LIMB_W, 8, limb width; fixed to match the adder, not user-overridable (localparam taken from the package).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  1  request operands are valid.
req_ready  output  1  block can accept a request.
req_a  input  WORDS*8  operand A.
req_b  input  WORDS*8  operand B.
req_c_in  input  1  carry into limb 0.
rsp_valid  output  1  result is valid.
rsp_ready  input  1  consumer accepts the result.
rsp_sum  output  WORDS*8  sum, modulo 2^(WORDS*8).
rsp_c_out  output  1  carry out of the top limb.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising clk edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: capture req_a, req_b into operand registers; carry_q <= req_c_in; idx <= 0; go to RUN.
- RUN:
  - Each cycle, drive the adder with a = A[idx], b = B[idx], c_in = carry_q.
  - Register: result[idx] <= sum; carry_q <= c_out.
  - If idx == WORDS-1, go to DONE; otherwise idx <= idx+1.
- DONE:
  - rsp_valid=1; rsp_sum = result register; rsp_c_out = carry_q.
  - On rsp_ready, go to IDLE.
- Latency: rsp_valid rises exactly WORDS cycles after the request-acceptance edge. Minimum request-to-request spacing is WORDS+2 cycles.
- Request inputs are ignored outside IDLE: req_ready=0 in RUN and DONE, and the captured operands must not change.
- rsp_sum and rsp_c_out are registered and held stable while rsp_valid=1 and rsp_ready=0. Their values outside DONE are don't-care, except at reset.
- No combinational path from req_valid to req_ready, or from rsp_ready to rsp_valid. Both ready/valid outputs are decoded from state only.
- WORDS=1 boundary: a single RUN cycle; rsp_valid appears 1 cycle after acceptance.
- Carry propagation: the full ripple occurs across cycles. All-ones plus c_in=1 must wrap to 0 with rsp_c_out=1.
- Reset (any state, including mid-RUN or DONE with rsp_ready=0):
  - Next state IDLE; the in-flight operation is discarded and no response is produced.
  - Reset values: req_ready=1, rsp_valid=0, busy=0, rsp_sum=0, rsp_c_out=0, idx=0, carry_q=0.
- idx width: $clog2(WORDS) bits, minimum 1.

Decomposition:
- Package adder_seq_pkg: LIMB_W=8 constant, MAX_WORDS=16 constant, state enum typedef (IDLE, RUN, DONE).
- One sub-module: the existing 8-bit adder module adder (ports a, b, c_in, sum, c_out), instantiated once as the shared datapath.
- The controller holds the FSM, idx counter, carry register, operand registers and result register.

Test Plan:
1. WORDS=4, A=0x000000FF, B=0x00000001, c_in=0, rsp_ready=1 -> rsp_sum=0x00000100, rsp_c_out=0; rsp_valid exactly 4 cycles after acceptance.
2. A=0xFFFFFFFF, B=0x00000000, c_in=1 -> rsp_sum=0x00000000, rsp_c_out=1.
3. A=0x12345678, B=0x11111111, rsp_ready held 0 for 5 cycles in DONE -> rsp_valid and rsp_sum=0x23456789 held stable; req_ready=0; a concurrent req_valid is not accepted until after the response handshake.
4. Back-to-back: req_valid held high with two ops (0x00000005 + 0x00000007, then 0x80000000 + 0x80000000) -> responses 0x0000000C/c_out=0, then 0x00000000/c_out=1; second acceptance occurs the cycle after the first response handshake.
5. rst=1 for one cycle after 2 limbs of RUN (A=0xFFFFFFFF, B=1) -> following cycle: state IDLE, req_ready=1, rsp_valid=0, busy=0, rsp_sum=0; no response is ever produced for the aborted operation.
6. WORDS=1, A=200, B=100, c_in=0 -> rsp_sum=44 (0x2C), rsp_c_out=1; rsp_valid 1 cycle after acceptance.
